// File: rtl/bandpass3_ctl_pkg.sv
// Shared types for the bandpass3 control block: sequencer states and coefficient width.
package bandpass3_ctl_pkg;
  localparam int COEF_W = 17;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;
endpackage

// File: rtl/bandpass_decim.sv
// Free-running oe decimation counter, 0..decim, one pulse per wrap.
// A shrinking decim below the current count forces a wrap on the next edge.
module bandpass_decim #(
  parameter int DECIM_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DECIM_W-1:0] decim,
  output logic               oe
);

  logic [DECIM_W-1:0] cnt;
  logic [DECIM_W-1:0] cnt_n;

  always_comb begin
    cnt_n = (cnt >= decim) ? '0 : cnt + DECIM_W'(1);
  end

  // oe is registered alongside the count so it is high exactly while cnt==0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      oe  <= 1'b0;
    end else begin
      cnt <= cnt_n;
      oe  <= (cnt_n == '0);
    end
  end

endmodule

// File: rtl/bandpass3_ctl.sv
// Coefficient holder and clear/settle sequencer for one bandpass3 filter.
// All outputs registered; oe comes from the bandpass_decim counter.
module bandpass3_ctl
  import bandpass3_ctl_pkg::*;
#(
  parameter int CLR_CYCLES = 4,
  parameter int SETTLE_W   = 12,
  parameter int DECIM_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [COEF_W-1:0] new_cm1,
  input  logic signed [COEF_W-1:0] new_d,
  input  logic                     load,
  input  logic                     clear_req,
  input  logic                     clr_on_load,
  input  logic [SETTLE_W-1:0]      settle_len,
  input  logic [DECIM_W-1:0]       decim,
  output logic signed [COEF_W-1:0] cm1,
  output logic signed [COEF_W-1:0] d,
  output logic                     zerome,
  output logic                     oe,
  output logic                     out_stb,
  output logic                     valid,
  output logic                     busy
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  state_t              state, state_n;
  logic [CLR_W-1:0]    clr_cnt, clr_cnt_n;
  logic [SETTLE_W-1:0] set_cnt, set_cnt_n;
  logic [SETTLE_W-1:0] set_len, set_len_n;
  logic                clear_evt;
  logic                zerome_n, valid_n, busy_n;

  bandpass_decim #(.DECIM_W(DECIM_W)) u_decim (
    .clk   (clk),
    .rst   (rst),
    .decim (decim),
    .oe    (oe)
  );

  assign clear_evt = clear_req | (load & clr_on_load);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      set_cnt <= '0;
      set_len <= '0;
      cm1     <= '0;
      d       <= '0;
      zerome  <= 1'b1;
      valid   <= 1'b0;
      busy    <= 1'b1;
      out_stb <= 1'b0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
      set_cnt <= set_cnt_n;
      set_len <= set_len_n;
      zerome  <= zerome_n;
      valid   <= valid_n;
      busy    <= busy_n;
      out_stb <= oe & valid_n;
      if (load) begin
        cm1 <= new_cm1;
        d   <= new_d;
      end
    end
  end

  // A clear event always wins and restarts the clear, which also extends an ongoing one
  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    set_cnt_n = set_cnt;
    set_len_n = set_len;
    if (clear_evt) begin
      state_n   = ST_CLEAR;
      clr_cnt_n = '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            set_len_n = settle_len;
            set_cnt_n = '0;
            state_n   = (settle_len == '0) ? ST_RUN : ST_SETTLE;
          end else begin
            clr_cnt_n = clr_cnt + CLR_W'(1);
          end
        end
        ST_SETTLE: begin
          if (set_cnt == set_len - SETTLE_W'(1)) begin
            state_n = ST_RUN;
          end else begin
            set_cnt_n = set_cnt + SETTLE_W'(1);
          end
        end
        ST_RUN: begin
          // A coefficient step without a clear still needs the resonance to re-settle
          if (load && settle_len != '0) begin
            state_n   = ST_SETTLE;
            set_len_n = settle_len;
            set_cnt_n = '0;
          end
        end
        default: state_n = ST_CLEAR;
      endcase
    end
  end

  always_comb begin
    zerome_n = (state_n == ST_CLEAR);
    valid_n  = (state_n == ST_RUN);
    busy_n   = (state_n != ST_RUN);
  end

endmodule

// File: tb/tb_bandpass3_ctl.sv
// Directed-vector bench for bandpass3_ctl with hand-computed expectations.
module tb_bandpass3_ctl;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [16:0] new_cm1 = '0;
  logic signed [16:0] new_d = '0;
  logic               load = 1'b0;
  logic               clear_req = 1'b0;
  logic               clr_on_load = 1'b0;
  logic [11:0]        settle_len = 12'd10;
  logic [7:0]         decim = 8'd0;
  logic signed [16:0] cm1;
  logic signed [16:0] d;
  logic               zerome, oe, out_stb, valid, busy;

  int total = 0;
  int bad = 0;

  bandpass3_ctl #(.CLR_CYCLES(4), .SETTLE_W(12), .DECIM_W(8)) dut (
    .clk(clk), .rst(rst), .new_cm1(new_cm1), .new_d(new_d), .load(load),
    .clear_req(clear_req), .clr_on_load(clr_on_load), .settle_len(settle_len),
    .decim(decim), .cm1(cm1), .d(d), .zerome(zerome), .oe(oe),
    .out_stb(out_stb), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic count_zerome(output int n);
    n = 0;
    while (zerome && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    #12;
    total++;
    if ({cm1, d, zerome, oe, out_stb, valid, busy} !== {17'sd0, 17'sd0, 5'b10001}) begin
      bad++;
      $display("FAIL reset_values got cm1=%0d d=%0d z/oe/stb/v/b=%b%b%b%b%b", cm1, d, zerome, oe, out_stb, valid, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (zerome !== (i < 4) || busy !== (i < 14) || valid !== (i >= 14)) begin
        bad++;
        $display("FAIL reset_seq cycle=%0d got z=%b b=%b v=%b", i, zerome, busy, valid);
      end
      tick();
    end
    wait_valid(n);
  endtask

  task automatic test_load_clr;
    int n;
    new_cm1 = -17'sd1000; new_d = 17'sd500; clr_on_load = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (cm1 !== -17'sd1000 || d !== 17'sd500 || zerome !== 1'b1 || valid !== 1'b0) begin
      bad++;
      $display("FAIL load_clr_edge got cm1=%0d d=%0d z=%b v=%b exp -1000 500 1 0", cm1, d, zerome, valid);
    end
    wait_valid(n);
    total++;
    if (n !== 14) begin
      bad++;
      $display("FAIL load_clr_valid_gap got=%0d exp=14", n);
    end
  endtask

  task automatic test_load_noclr;
    int n;
    settle_len = 12'd5; clr_on_load = 1'b0;
    new_cm1 = 17'sd1234; new_d = -17'sd7; load = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (cm1 !== 17'sd1234 || d !== -17'sd7 || zerome !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL load_noclr_edge got cm1=%0d d=%0d z=%b b=%b exp 1234 -7 0 1", cm1, d, zerome, busy);
    end
    wait_valid(n);
    total++;
    if (n !== 5) begin
      bad++;
      $display("FAIL load_noclr_settle got=%0d exp=5", n);
    end
    settle_len = 12'd10;
  endtask

  task automatic test_simultaneous;
    int n;
    clr_on_load = 1'b1; new_cm1 = 17'sd42; new_d = 17'sd43;
    load = 1'b1; clear_req = 1'b1;
    tick();
    load = 1'b0; clear_req = 1'b0;
    total++;
    if (cm1 !== 17'sd42 || d !== 17'sd43) begin
      bad++;
      $display("FAIL simul_coef got cm1=%0d d=%0d exp 42 43", cm1, d);
    end
    count_zerome(n);
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL simul_clear_len got=%0d exp=4", n);
    end
    wait_valid(n);
    clr_on_load = 1'b0;
  endtask

  task automatic test_extend;
    int n;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (zerome && n < 50) begin
      n++;
      if (n == 2) clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
    end
    total++;
    if (n !== 6) begin
      bad++;
      $display("FAIL extend_clear_len got=%0d exp=6", n);
    end
    wait_valid(n);
  endtask

  task automatic test_decim;
    int n;
    decim = 8'd6;
    n = 0;
    while (!oe && n < 50) begin
      tick();
      n++;
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      total++;
      if (oe !== (i == 7)) begin
        bad++;
        $display("FAIL decim6_period i=%0d got=%b exp=%b", i, oe, (i == 7));
      end
    end
    for (int i = 0; i < 5; i++) tick();
    decim = 8'd2;
    tick();
    total++;
    if (oe !== 1'b1) begin
      bad++;
      $display("FAIL decim_shrink_wrap got=%b exp=1", oe);
    end
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (oe !== (i % 3 == 0)) begin
        bad++;
        $display("FAIL decim2_period i=%0d got=%b exp=%b", i, oe, (i % 3 == 0));
      end
    end
    decim = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (oe !== 1'b1) begin
        bad++;
        $display("FAIL decim0_cont i=%0d got=%b exp=1", i, oe);
      end
    end
  endtask

  task automatic test_out_stb;
    logic prev;
    int   noe;
    decim = 8'd3;
    tick(); tick();
    prev = oe;
    noe = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 40) clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      if (oe) noe++;
      total++;
      if (out_stb !== (prev & valid)) begin
        bad++;
        $display("FAIL out_stb i=%0d got=%b exp=%b (v=%b)", i, out_stb, prev & valid, valid);
      end
      prev = oe;
    end
    total++;
    if (noe !== 15) begin
      bad++;
      $display("FAIL oe_count_through_clear got=%0d exp=15", noe);
    end
  endtask

  task automatic test_rst_mid;
    int n;
    settle_len = 12'd10;
    wait_valid(n);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (busy !== 1'b1 || zerome !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_precond got b=%b z=%b exp 1 0", busy, zerome);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({cm1, d, zerome, oe, out_stb, valid, busy} !== {17'sd0, 17'sd0, 5'b10001}) begin
      bad++;
      $display("FAIL rst_async got cm1=%0d d=%0d z/oe/stb/v/b=%b%b%b%b%b", cm1, d, zerome, oe, out_stb, valid, busy);
    end
    tick();
    rst = 1'b0;
    count_zerome(n);
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL rst_restart_clear got=%0d exp=4", n);
    end
    wait_valid(n);
    total++;
    if (n !== 10 || cm1 !== 17'sd0 || d !== 17'sd0) begin
      bad++;
      $display("FAIL rst_restart_settle got=%0d cm1=%0d d=%0d exp 10 0 0", n, cm1, d);
    end
  endtask

  initial begin
    test_reset();
    test_load_clr();
    test_load_noclr();
    test_simultaneous();
    test_extend();
    test_decim();
    test_out_stb();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
